// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits, optional parity (CHECK_MODE), one stop bit, mid-bit sampling.
// Define UART_RX_GLITCH_FILTER_EN to take each bit as a 2-of-3 majority around mid-bit.
module uart_receiver #(
  parameter int    CLK_FREQUENCY = 60_000_000,
  parameter int    BAUD_RATE     = 115_200,
  parameter string CHECK_MODE    = "NO",
  localparam int   CNT_NUM       = CLK_FREQUENCY / BAUD_RATE
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rxd,
  output logic       o_busy,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_parity_err,
  output logic       o_frame_err
);

  localparam int CW      = $clog2(CNT_NUM);
  localparam int MID     = CNT_NUM / 2;
  localparam bit PAR_ODD = (CHECK_MODE == "ODD");
  localparam bit PAR_EN  = (CHECK_MODE == "ODD") || (CHECK_MODE == "EVEN");

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            sync1_q, rxd_s_q, rxd_prev_q;
  logic            sample, decide, wrap;

`ifdef UART_RX_GLITCH_FILTER_EN
  localparam int DEC_CNT = MID + 1;
  logic rxd_prev2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rxd_prev2_q <= 1'b1;
    else          rxd_prev2_q <= rxd_prev_q;
  end

  // Majority of rxd_s over the three cycles ending at the decision count.
  assign sample = (rxd_prev2_q & rxd_prev_q) | (rxd_prev2_q & rxd_s_q) | (rxd_prev_q & rxd_s_q);
`else
  localparam int DEC_CNT = MID;
  assign sample = rxd_s_q;
`endif

  assign decide = (baud_cnt_q == CW'(DEC_CNT));
  assign wrap   = (baud_cnt_q == CW'(CNT_NUM - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q    <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= i_rxd;
      rxd_s_q    <= sync1_q;
      rxd_prev_q <= rxd_s_q;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = wrap ? '0 : baud_cnt_q + CW'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (rxd_prev_q && !rxd_s_q) state_d = S_START;
      end
      S_START: begin
        if (decide && sample) begin
          state_d    = S_IDLE;
          baud_cnt_d = '0;
        end else if (wrap) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (decide) shift_d = {sample, shift_q[7:1]};
        if (wrap) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (decide) par_d = sample;
        if (wrap) state_d = S_STOP;
      end
      S_STOP: begin
        // Leave at the stop decision so a start edge right after the stop bit is caught.
        if (decide) begin
          state_d    = S_IDLE;
          baud_cnt_d = '0;
          rx_valid_d = 1'b1;
          rx_data_d  = shift_q;
          ferr_d     = !sample;
          if (PAR_EN) perr_d = PAR_ODD ? ~^{shift_q, par_q} : ^{shift_q, par_q};
          else        perr_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  assign o_busy       = (state_q != S_IDLE);
  assign o_rx_valid   = rx_valid_q;
  assign o_rx_data    = rx_data_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 60_000_000, the i_clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, the line bit rate.
REQ-003 SHALL have parameter CHECK_MODE, default "NO", the parity mode: "NO", "ODD" or "EVEN"; any other value is treated as "NO".
REQ-004 SHALL have derived parameter CNT_NUM, equal to CLK_FREQUENCY / BAUD_RATE (integer division), the clocks per bit; it is not overridden at instantiation.
REQ-005 SHALL have port i_clk, input, 1 bit, the clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-007 SHALL have port i_rxd, input, 1 bit, the serial line; it is asynchronous and idles high.
REQ-008 SHALL have port o_busy, output, 1 bit, high while a frame is being received.
REQ-009 SHALL have port o_rx_valid, output, 1 bit, a one-cycle pulse marking a completed frame.
REQ-010 SHALL have port o_rx_data, output, 8 bits, the received byte; it is stable from the o_rx_valid pulse until the next o_rx_valid pulse.
REQ-011 SHALL have port o_parity_err, output, 1 bit, the parity check result; it is qualified by o_rx_valid.
REQ-012 SHALL have port o_frame_err, output, 1 bit, the stop-bit check result; it is qualified by o_rx_valid.

Function
REQ-013 SHALL synchronise i_rxd through 2 flip-flops, reset to 1; all logic uses only the synchronised value rxd_s.
REQ-014 SHALL run an FSM with states IDLE, START, DATA, PARITY and STOP, one-hot or encoded.
REQ-015 SHALL move from IDLE to START when rxd_s falls (previous value 1, current value 0), clearing the baud counter to 0 in that cycle.
REQ-016 SHALL count the baud counter 0..CNT_NUM-1 in every non-IDLE state and wrap it to 0; it holds 0 in IDLE.
REQ-017 SHALL take each bit's sample decision at baud_cnt == CNT_NUM/2 (mid-bit).
REQ-018 SHALL return from START to IDLE if the start sample is 1 (false start), with no output pulse; if the sample is 0, it SHALL go to DATA at the next wrap.
REQ-019 SHALL sample 8 data bits in DATA, LSB first, using a 3-bit bit counter; after bit 7 it SHALL go to PARITY if CHECK_MODE is "ODD" or "EVEN", otherwise to STOP.
REQ-020 SHALL set the parity error in ODD mode when the ones count of data plus parity bit is even, and in EVEN mode when it is odd; in NO mode it SHALL always be 0.
REQ-021 SHALL set the frame error when the stop sample is 0.
REQ-022 SHALL move from STOP to IDLE in the cycle after the stop decision, without waiting for the end of the stop bit, so a back-to-back start edge is accepted.
REQ-023 SHALL assert o_rx_valid for exactly 1 cycle, 1 cycle after the stop decision, and update o_rx_data, o_parity_err and o_frame_err in that same cycle.
REQ-024 SHALL still pulse o_rx_valid on errored frames, with the error flags set.
REQ-025 SHALL follow a break condition (line held 0) with frame_err=1 and data 0x00; a new frame SHALL NOT start until rxd_s has returned to 1 and fallen again.
REQ-026 SHALL drive o_busy high in every state other than IDLE.

Reset
REQ-027 SHALL, on asynchronous reset, go to IDLE with baud_cnt=0, bit_cnt=0, o_busy=0, o_rx_valid=0, o_rx_data=0x00, o_parity_err=0, o_frame_err=0 and both synchroniser flops at 1.
REQ-028 SHALL, on reset mid-frame, abandon the frame with no o_rx_valid pulse, and reception SHALL resume on the next falling edge after release.

Configuration
REQ-029 SHALL, with macro UART_RX_GLITCH_FILTER_EN defined, take each bit value (start, data, parity, stop) as the 2-of-3 majority of rxd_s at baud_cnt CNT_NUM/2-1, CNT_NUM/2 and CNT_NUM/2+1; the decision occurs at CNT_NUM/2+1, and every output event in REQ-023 SHALL move 1 cycle later.
REQ-030 SHALL, without UART_RX_GLITCH_FILTER_EN, use a single sample at CNT_NUM/2 per REQ-017, with no extra latency.

Verification (60 MHz, 115200 baud, CNT_NUM=520)
REQ-031 SHALL cover a single frame: NO mode, byte 0xA5 sent -> one o_rx_valid pulse, o_rx_data=0xA5, both error flags 0, o_busy returning to 0.
REQ-032 SHALL cover parity: EVEN mode, 0x03 with parity 0 -> parity_err=0; then 0x03 with parity 1 -> parity_err=1 and valid still pulsed; ODD mode, 0x00 with parity 1 -> parity_err=0.
REQ-033 SHALL cover false start and framing error: 100-cycle low glitch on idle line -> no valid and o_busy back to 0 by cycle ~262; frame 0x55 with stop bit 0 -> frame_err=1 and data 0x55.
REQ-034 SHALL cover back-to-back frames: 0x00, 0xFF, 0x81 with zero idle gap -> three valid pulses in order, with correct data.
REQ-035 SHALL cover reset mid-frame: assert i_rst_n low during bit 4 of 0x3C, release, then send 0xC3 -> only one valid pulse, with data 0xC3.
REQ-036 SHALL cover the glitch filter: with UART_RX_GLITCH_FILTER_EN defined, a 1-cycle inverted spike at baud_cnt CNT_NUM/2 on each data bit of 0x5A -> data 0x5A; without the macro, the same stimulus -> data 0xA5.
